// File: rtl/io_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_hex_display_ctrl
// Purpose  : Output-side display stage for the pipelined CPU. Captures a
//            value written to the CPU out_port, converts its low CONV_W bits
//            to six BCD digits with a sequential shift-add-3 engine (one bit
//            per clock), and drives six active-low seven-segment displays.
//            Values above 999999 are shown as dashes with overflow raised.
// Ports    : clock        system clock, rising edge
//            resetn       synchronous active-low reset
//            value_in     value from CPU out_port (IN_W bits)
//            value_valid  one-cycle write strobe for value_in
//            busy         conversion loaded or in progress
//            done         one-cycle pulse alongside each display update
//            overflow     displayed value exceeds 999999
//            hex0..hex5   segments gfedcba, active-low, hex0 = ones digit
// Revision : 1.0  initial release
// ============================================================================
module io_hex_display_ctrl #(
  parameter int IN_W     = 32,
  parameter int CONV_W   = 20,
  parameter int BLANK_LZ = 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [IN_W-1:0] value_in,
  input  logic            value_valid,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [6:0]      hex0,
  output logic [6:0]      hex1,
  output logic [6:0]      hex2,
  output logic [6:0]      hex3,
  output logic [6:0]      hex4,
  output logic [6:0]      hex5
);

  localparam int             CNT_W    = $clog2(CONV_W + 1);
  localparam int             BCD_W    = 24;
  localparam logic [IN_W-1:0] MAX_DISP = IN_W'(999_999);
  localparam logic [6:0]     SEG_OFF  = 7'b1111111;
  localparam logic [6:0]     SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t            state;
  logic [CONV_W-1:0] shift_reg;
  logic [BCD_W-1:0]  bcd;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_pend;
  logic [IN_W-1:0]   pend_val;
  logic              pend_valid;

  // ---------------------------------------------------------------------------
  // Shift-add-3 step: correct every nibble >= 5, then shift the whole
  // {bcd, shift_reg} chain left by one so the next binary bit enters bcd.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+CONV_W-1:0] chain_next;
  logic [BCD_W-1:0]        bcd_next;
  logic [CONV_W-1:0]       shift_next;

  for (genvar g = 0; g < 6; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3
                                                        : bcd[4*g +: 4];
  end

  assign chain_next = {bcd_adj, shift_reg} << 1;
  assign bcd_next   = chain_next[BCD_W+CONV_W-1 -: BCD_W];
  assign shift_next = chain_next[CONV_W-1:0];

  // ---------------------------------------------------------------------------
  // Next load source. A strobe in UPDATE beats the pending buffer; in IDLE
  // only the strobe can trigger a load.
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0] load_val;
  logic            load_ovf;

  assign load_val = (state == ST_UPDATE && !value_valid) ? pend_val : value_in;
  assign load_ovf = (load_val > MAX_DISP);

  // ---------------------------------------------------------------------------
  // Segment decode of the finished BCD word, with optional leading-zero
  // blanking. upper_zero tracks "this digit and all above it are zero".
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_OFF;
    endcase
  endfunction

  logic [6:0] disp_seg [6];
  logic       upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      disp_seg[i] = SEG_OFF;
    end
    for (int i = 5; i >= 0; i--) begin
      upper_zero = upper_zero && (bcd[4*i +: 4] == 4'd0);
      if (BLANK_LZ != 0 && i != 0 && upper_zero) begin
        disp_seg[i] = SEG_OFF;
      end else begin
        disp_seg[i] = seg7(bcd[4*i +: 4]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      hex0       <= SEG_OFF;
      hex1       <= SEG_OFF;
      hex2       <= SEG_OFF;
      hex3       <= SEG_OFF;
      hex4       <= SEG_OFF;
      hex5       <= SEG_OFF;
      shift_reg  <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf_pend   <= 1'b0;
      pend_val   <= '0;
      pend_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (value_valid) begin
            shift_reg <= load_val[CONV_W-1:0];
            bcd       <= '0;
            cnt       <= '0;
            ovf_pend  <= load_ovf;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          bcd       <= bcd_next;
          shift_reg <= shift_next;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CONV_W - 1)) begin
            state <= ST_UPDATE;
          end
          // One-deep buffer: the most recent write replaces any earlier one.
          if (value_valid) begin
            pend_val   <= value_in;
            pend_valid <= 1'b1;
          end
        end

        ST_UPDATE: begin
          done <= 1'b1;
          if (ovf_pend) begin
            hex0     <= SEG_DASH;
            hex1     <= SEG_DASH;
            hex2     <= SEG_DASH;
            hex3     <= SEG_DASH;
            hex4     <= SEG_DASH;
            hex5     <= SEG_DASH;
            overflow <= 1'b1;
          end else begin
            hex0     <= disp_seg[0];
            hex1     <= disp_seg[1];
            hex2     <= disp_seg[2];
            hex3     <= disp_seg[3];
            hex4     <= disp_seg[4];
            hex5     <= disp_seg[5];
            overflow <= 1'b0;
          end
          // Pending value is consumed or superseded either way.
          pend_valid <= 1'b0;
          if (value_valid || pend_valid) begin
            shift_reg <= load_val[CONV_W-1:0];
            bcd       <= '0;
            cnt       <= '0;
            ovf_pend  <= load_ovf;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_hex_display_ctrl
// Purpose  : Scoreboard bench for io_hex_display_ctrl. Two instances (leading
//            zero blanking on and off) share one stimulus stream. A
//            transaction-level model predicts which values reach the display
//            and when; a monitor pops predictions on each done pulse and
//            checks segments, overflow and busy every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_hex_display_ctrl;

  localparam int LAT = 21;  // strobe edge to display-update edge

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] value_in = '0;
  logic        value_valid = 1'b0;

  logic       busy_b, done_b, ovf_b, busy_n, done_n, ovf_n;
  logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5;
  logic [6:0] hn0, hn1, hn2, hn3, hn4, hn5;

  io_hex_display_ctrl #(.IN_W(32), .CONV_W(20), .BLANK_LZ(1)) dut_b (
    .clock(clock), .resetn(resetn), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_b), .done(done_b), .overflow(ovf_b),
    .hex0(hb0), .hex1(hb1), .hex2(hb2), .hex3(hb3), .hex4(hb4), .hex5(hb5)
  );

  io_hex_display_ctrl #(.IN_W(32), .CONV_W(20), .BLANK_LZ(0)) dut_n (
    .clock(clock), .resetn(resetn), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_n), .done(done_n), .overflow(ovf_n),
    .hex0(hn0), .hex1(hn1), .hex2(hn2), .hex3(hn3), .hex4(hn4), .hex5(hn5)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference: decimal digits by division, segment table straight from the
  // digit encoding list.
  // --------------------------------------------------------------------------
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  function automatic logic [41:0] exp_hex(input longint v, input bit blank);
    logic [41:0] r;
    longint p;
    r = '1;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      if (v < 0)                          r[7*i +: 7] = 7'b1111111;
      else if (v > 999999)                r[7*i +: 7] = 7'b0111111;
      else if (blank && i > 0 && v < p)   r[7*i +: 7] = 7'b1111111;
      else                                r[7*i +: 7] = seg_tab[int'((v / p) % 10)];
      p = p * 10;
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Transaction model: which value is being converted, when it lands, and
  // the one-deep pending slot.
  // --------------------------------------------------------------------------
  typedef struct { longint val; int cyc; } exp_t;
  exp_t   q[$];
  bit     active = 1'b0;
  longint cur_val;
  int     upd_cyc;
  bit     pend_v = 1'b0;
  longint pend_val;
  bit     exp_busy = 1'b0;

  task automatic model_step(input bit v, input logic [31:0] d, input bit rn);
    int c;
    c = cyc + 1;  // edge that is about to sample these inputs
    if (!rn) begin
      active = 1'b0;
      pend_v = 1'b0;
      q.delete();
    end else if (active && c == upd_cyc) begin
      q.push_back('{cur_val, c});
      if (v) begin
        cur_val = longint'(d); upd_cyc = c + LAT; pend_v = 1'b0;
      end else if (pend_v) begin
        cur_val = pend_val; upd_cyc = c + LAT; pend_v = 1'b0;
      end else begin
        active = 1'b0;
      end
    end else if (active) begin
      if (v) begin pend_val = longint'(d); pend_v = 1'b1; end
    end else if (v) begin
      active = 1'b1; cur_val = longint'(d); upd_cyc = c + LAT;
    end
    exp_busy = active;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit rn);
    @(negedge clock);
    resetn      = rn;
    value_valid = v;
    value_in    = d;
    model_step(v, d, rn);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, $urandom, 1'b1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (active && k < 200) begin
      idle(1);
      k++;
    end
    if (active) begin
      checks++; failures++;
      $display("FAIL drain_timeout: model still busy after %0d cycles", k);
    end
    idle(2);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: samples 1 time unit after each rising edge.
  // --------------------------------------------------------------------------
  longint shown = -1;

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (!resetn) shown = -1;
        chk("done_pair", {63'd0, done_n}, {63'd0, done_b});
        if (done_b === 1'b1) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
          end else begin
            e = q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            shown = e.val;
          end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          checks++; failures++;
          $display("FAIL missed_done at cycle %0d: got done=0 expected done=1 at %0d", cyc, e.cyc);
          shown = e.val;
        end
        chk("busy_b", {63'd0, busy_b}, {63'd0, exp_busy});
        chk("busy_n", {63'd0, busy_n}, {63'd0, exp_busy});
        chk("hex_blank",   {22'd0, hb5, hb4, hb3, hb2, hb1, hb0}, {22'd0, exp_hex(shown, 1'b1)});
        chk("hex_noblank", {22'd0, hn5, hn4, hn3, hn2, hn1, hn0}, {22'd0, exp_hex(shown, 1'b0)});
        chk("overflow_b", {63'd0, ovf_b}, {63'd0, (shown > 999999)});
        chk("overflow_n", {63'd0, ovf_n}, {63'd0, (shown > 999999)});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int r;
    logic [31:0] v;

    drive(1'b0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    mon_en = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    chk("rst_hex", {22'd0, hb5, hb4, hb3, hb2, hb1, hb0}, {22'd0, {6{7'h7F}}});
    chk("rst_busy", {63'd0, busy_b}, 64'd0);
    chk("rst_done", {63'd0, done_b}, 64'd0);
    chk("rst_ovf",  {63'd0, ovf_b}, 64'd0);

    // Basic conversions, zero, small value, overflow and recovery
    drive(1'b1, 32'd123456, 1'b1);  wait_idle();
    drive(1'b1, 32'd7, 1'b1);       wait_idle();
    drive(1'b1, 32'd0, 1'b1);       wait_idle();
    drive(1'b1, 32'd1000000, 1'b1); wait_idle();
    drive(1'b1, 32'd42, 1'b1);      wait_idle();
    drive(1'b1, 32'd999999, 1'b1);  wait_idle();
    drive(1'b1, 32'hFFFF_FFFF, 1'b1); wait_idle();

    // Writes during a conversion: last pending write wins
    drive(1'b1, 32'd111, 1'b1);
    idle(2);
    drive(1'b1, 32'd222, 1'b1);
    idle(1);
    drive(1'b1, 32'd333, 1'b1);
    wait_idle();

    // Strobe exactly on the update edge overrides the pending value
    drive(1'b1, 32'd10, 1'b1);
    idle(5);
    drive(1'b1, 32'd20, 1'b1);
    idle(14);
    drive(1'b1, 32'd30, 1'b1);
    wait_idle();

    // Reset mid-conversion, then a normal conversion
    drive(1'b1, 32'd999999, 1'b1);
    idle(9);
    drive(1'b0, 32'd0, 1'b0);
    idle(3);
    drive(1'b1, 32'd5, 1'b1);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 199);
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 999999);
        2:       v = $urandom;
        default: v = $urandom_range(999990, 1000010);
      endcase
      if (r < 2)       drive(1'b0, v, 1'b0);
      else if (r < 30) drive(1'b1, v, 1'b1);
      else             drive(1'b0, v, 1'b1);
    end
    wait_idle();
    idle(3);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/io_hex_display_ctrl.md
Name: io_hex_display_ctrl

Overview:
Output-side I/O stage that sits directly downstream of the pipelined computer's output ports. It accepts a 32-bit value written by the CPU and converts it to six decimal digits using a sequential shift-add-3 (double-dabble) engine. It then drives six active-low seven-segment displays (hex5..hex0). It replaces direct binary-to-hex decoding so that board displays show decimal results.

Parameters:
IN_W, 32, width of value_in (CPU out_port width)
CONV_W, 20, number of low bits converted; one shift per cycle
BLANK_LZ, 1, 1 = blank leading zero digits (hex0 is never blanked); 0 = show all six digits

Ports:
clock  in  1  system clock; all state updates on rising edge
resetn  in  1  synchronous active-low reset, sampled on the rising edge of clock
value_in  in  IN_W  value from CPU out_port
value_valid  in  1  one-cycle write strobe; value_in is valid on this cycle
busy  out  1  high while a conversion is loaded or in progress
done  out  1  one-cycle pulse in the cycle after the displays update
overflow  out  1  high when the displayed value is greater than 999999
hex0..hex5  out  7 each  segments, active-low, bit order gfedcba; hex0 is the least significant digit

Behaviour:
- Reset: when resetn=0 at an edge, state goes to IDLE. Outputs: busy=0, done=0, overflow=0, hex0..hex5=7'h7F (all segments off). The pending buffer is cleared.
- Reset mid-conversion aborts the conversion. Displays go to 7'h7F and the in-flight value is discarded.
- Reset has priority over value_valid.
- State machine: IDLE, SHIFT, UPDATE.
- IDLE:
  - If value_valid=1 at edge N: load shift_reg=value_in[CONV_W-1:0], clear the 24-bit BCD register and the shift counter.
  - At the same edge set ovf_pend=1 if value_in > 999999 (compare the full IN_W bits).
  - Go to SHIFT; busy=1 from edge N.
- SHIFT, one step per edge:
  - Add 3 to each BCD nibble that is >=5.
  - Then shift {bcd, shift_reg} left by one bit.
  - Increment the counter.
  - After CONV_W steps (edges N+1..N+CONV_W), go to UPDATE.
- UPDATE, at edge N+CONV_W+1:
  - If ovf_pend=1: all six hex outputs = 7'b0111111 (dash) and overflow=1.
  - Otherwise: each hex output shows its BCD digit and overflow=0. With BLANK_LZ=1, any digit above the most significant nonzero digit is 7'h7F.
  - done=1 for exactly the following cycle.
  - If a value is pending, load it as in IDLE and go to SHIFT (busy stays 1). Otherwise go to IDLE and busy=0.
- Latency: strobe at edge N gives hex update at edge N+CONV_W+1, which is 21 with defaults.
- Writes during a conversion:
  - A value_valid during SHIFT stores value_in into a one-deep pending buffer. The last write wins and earlier pending values are overwritten.
  - A value_valid during UPDATE is taken as the immediate next load. It takes priority over, and discards, the pending value.
- The hex outputs are registers and hold their last value until the next UPDATE.
- Digit encoding (active-low gfedcba):
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  Blank = 1111111. Dash = 0111111.
- A value of 0 shows 1000000 on hex0. With BLANK_LZ=1, hex1..hex5 are blank.

Test Plan:
- Reset: hold resetn=0 for 2 edges then release -> hex0..5=7'h7F, busy=0, done=0, overflow=0.
- Strobe value_in=123456 at edge N -> busy=1 during N..N+20; at edge N+21 hex5..hex0 show digits 1,2,3,4,5,6; done=1 for one cycle; overflow=0.
- Strobe value_in=7 with BLANK_LZ=1 -> hex0=1111000, hex1..5=1111111. Same value with BLANK_LZ=0 -> hex1..5=1000000.
- Strobe value_in=1000000 -> all hex=0111111 and overflow=1. A following strobe of 42 -> overflow=0 and the display shows 42.
- Strobe 111 at edge N, then 222 at N+3 and 333 at N+5 -> the display shows 111 at N+21. It then shows 333 at N+42. 222 is never displayed. busy stays 1 from N through N+41.
- Strobe 999999, then assert resetn=0 at N+10 -> hex all 7'h7F, busy=0, no done pulse. A later strobe of 5 converts normally with 21-cycle latency.
